decoder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 2-to-4 `decoder` between four requesters. It picks one requester and drives the 2-bit select pair (`sel_a`, `sel_b`) into the existing `decoder`. The decoder's one-hot outputs form the grant vector. The block sits between the request sources and the decoder, and it holds a grant until the owner releases it.

---
 rtl/decoder_arb_pkg.sv | 12 +
 rtl/decoder.sv | 16 +
 rtl/decoder_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared constants for the decoder round-robin arbiter: state encoding,
// requester count and grant index width.
package decoder_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

endpackage

// File: rtl/decoder.sv
// Existing 2-to-4 one-hot decoder; {b, a} selects which y output is high.
module decoder (
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign y0 = ~b & ~a;
  assign y1 = ~b &  a;
  assign y2 =  b & ~a;
  assign y3 =  b &  a;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter steering the shared 2-to-4 decoder among four requesters.
// Optional grant timeout is built when DECODER_ARB_TIMEOUT_EN is defined.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             sel_a,
  output logic             sel_b,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic             to_pulse
);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] pick;
  logic             y0, y1, y2, y3;

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`else
  logic unused_hold_max;
  assign unused_hold_max = ^8'(HOLD_MAX);
`endif

  // First set request at or after last+1, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = last + IDX_W'(i);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick = rr_pick(req, last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
`ifdef DECODER_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = pick;
          last_d  = pick;
          vld_d   = 1'b1;
`ifdef DECODER_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = GAP;
          vld_d   = 1'b0;
        end
`ifdef DECODER_ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d = GAP;
          vld_d   = 1'b0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      sel_q   <= '0;
      vld_q   <= 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
`ifdef DECODER_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  decoder u_decoder (
    .a  (sel_q[0]),
    .b  (sel_q[1]),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3)
  );

  assign sel_a   = sel_q[0];
  assign sel_b   = sel_q[1];
  assign gnt_vld = vld_q;
  assign gnt     = {y3, y2, y1, y0} & {N_REQ{vld_q}};

`ifdef DECODER_ARB_TIMEOUT_EN
  assign to_pulse = to_q;
`else
  assign to_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter; timeout checks follow DECODER_ARB_TIMEOUT_EN.
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       sel_a;
  logic       sel_b;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic       to_pulse;

  int tests_run;
  int tests_failed;

  decoder_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .to_pulse (to_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    do_reset(3);
    tests_run++;
    if (gnt !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt);
    end
    tests_run++;
    if ({sel_b, sel_a} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_sel: got %b want 00", {sel_b, sel_a});
    end
    tests_run++;
    if (gnt_vld !== 1'b0) begin
      tests_failed++; $display("FAIL reset_vld: got %b want 0", gnt_vld);
    end
    tests_run++;
    if (to_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL reset_to: got %b want 0", to_pulse);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0000;
    do_reset(1);
    req = 4'b0100;
    tick();
    tests_run++;
    if (gnt !== 4'b0100) begin
      tests_failed++; $display("FAIL single_gnt: got %b want 0100", gnt);
    end
    tests_run++;
    if ({sel_b, sel_a} !== 2'b10) begin
      tests_failed++; $display("FAIL single_sel: got %b want 10", {sel_b, sel_a});
    end
    tests_run++;
    if (gnt_vld !== 1'b1) begin
      tests_failed++; $display("FAIL single_vld: got %b want 1", gnt_vld);
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      tests_failed++; $display("FAIL single_release: got gnt %b vld %b want 0000/0", gnt, gnt_vld);
    end
    tests_run++;
    if ({sel_b, sel_a} !== 2'b10) begin
      tests_failed++; $display("FAIL single_gap_sel: got %b want 10", {sel_b, sel_a});
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0000) begin
      tests_failed++; $display("FAIL single_idle: got %b want 0000", gnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    int         o;
    req = 4'b0000;
    do_reset(1);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      exp_g = 4'b0001 << o;
      for (int c = 0; c < 3; c++) begin
        tests_run++;
        if (gnt !== exp_g) begin
          tests_failed++; $display("FAIL rot_grant k=%0d c=%0d: got %b want %b", k, c, gnt, exp_g);
        end
        if (c < 2) tick();
      end
      tests_run++;
      if ({sel_b, sel_a} !== 2'(o)) begin
        tests_failed++; $display("FAIL rot_sel k=%0d: got %b want %b", k, {sel_b, sel_a}, 2'(o));
      end
      req[o] = 1'b0;
      tick();
      tests_run++;
      if (gnt !== 4'b0000) begin
        tests_failed++; $display("FAIL rot_gap k=%0d: got %b want 0000", k, gnt);
      end
      req[o] = 1'b1;
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_no_preempt();
    req = 4'b0000;
    do_reset(1);
    req = 4'b0010;
    tick();
    tests_run++;
    if (gnt !== 4'b0010) begin
      tests_failed++; $display("FAIL nopre_first: got %b want 0010", gnt);
    end
    req = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0010) begin
        tests_failed++; $display("FAIL nopre_hold c=%0d: got %b want 0010", c, gnt);
      end
    end
    req = 4'b0001;
    tick();
    tests_run++;
    if (gnt !== 4'b0000) begin
      tests_failed++; $display("FAIL nopre_gap: got %b want 0000", gnt);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || {sel_b, sel_a} !== 2'b00) begin
      tests_failed++; $display("FAIL nopre_next: got gnt %b sel %b want 0001/00", gnt, {sel_b, sel_a});
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    req = 4'b0000;
    do_reset(1);
    req = 4'b1000;
    tick();
    tests_run++;
    if (gnt !== 4'b1000) begin
      tests_failed++; $display("FAIL midrst_pre: got %b want 1000", gnt);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || {sel_b, sel_a} !== 2'b00) begin
      tests_failed++; $display("FAIL midrst_clear: got gnt %b vld %b sel %b want 0000/0/00", gnt, gnt_vld, {sel_b, sel_a});
    end
    rst_n = 1'b1;
    req = 4'b1001;
    tick();
    tests_run++;
    if (gnt !== 4'b0001) begin
      tests_failed++; $display("FAIL midrst_next: got %b want 0001", gnt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0000;
    do_reset(1);
    req = 4'b0011;
`ifdef DECODER_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || to_pulse !== 1'b0) begin
        tests_failed++; $display("FAIL to_hold c=%0d: got gnt %b to %b want 0001/0", c, gnt, to_pulse);
      end
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || to_pulse !== 1'b1) begin
      tests_failed++; $display("FAIL to_gap: got gnt %b to %b want 0000/1", gnt, to_pulse);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || to_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL to_next: got gnt %b to %b want 0010/0", gnt, to_pulse);
    end
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || to_pulse !== 1'b0) begin
        tests_failed++; $display("FAIL noto_hold c=%0d: got gnt %b to %b want 0001/0", c, gnt, to_pulse);
      end
    end
`endif
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_no_preempt();
    test_mid_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
